// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Sequences one animation frame per accepted base tick: erase, state update,
// redraw. Each draw-datapath phase is started with a 1-cycle go pulse and
// completed by a done input sampled only while waiting for it. A reloading
// sub-divider marks every FRAME_DIV-th frame as "slow" so game logic can step
// at a lower rate. Ticks arriving while a frame is in flight are dropped and
// counted as misses.
//
// Optional feature (macro FRAME_WATCHDOG_EN):
//   When defined, each wait state is bounded to WD_CYCLES cycles. On expiry the
//   FSM proceeds as though done had been sampled and raises a sticky wd_err.
//   When undefined, wait states hold indefinitely and wd_err is tied to 0.
//
// Parameters:
//   FRAME_DIV  frames per slow_step (1..2**SUB_W)
//   SUB_W      width of the frame sub-divider counter
//   MISS_W     width of the saturating missed-tick counter
//   WD_CYCLES  watchdog limit per wait state (watchdog build only)
//
// Ports:
//   clock          in   system clock, rising edge
//   resetn         in   asynchronous active-low reset
//   enable         in   level, 1 = accept new frames
//   tick_in        in   1-cycle frame tick
//   erase_done     in   erase datapath finished (level or pulse)
//   draw_done      in   draw datapath finished (level or pulse)
//   clear_overrun  in   1-cycle pulse, clears overrun and miss_count
//   erase_go       out  1-cycle erase start pulse
//   update_go      out  1-cycle object-update pulse
//   draw_go        out  1-cycle draw start pulse
//   slow_step      out  pulse with update_go on every FRAME_DIV-th frame
//   busy           out  high whenever a frame is in progress
//   overrun        out  sticky dropped-tick flag
//   miss_count     out  saturating dropped-tick count
//   frame_count    out  accepted frames, wrapping 16-bit
//   wd_err         out  sticky watchdog error
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int FRAME_DIV = 30,
    parameter int SUB_W     = 5,
    parameter int MISS_W    = 8,
    parameter int WD_CYCLES = 1023
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              enable,
    input  logic              tick_in,
    input  logic              erase_done,
    input  logic              draw_done,
    input  logic              clear_overrun,
    output logic              erase_go,
    output logic              update_go,
    output logic              draw_go,
    output logic              slow_step,
    output logic              busy,
    output logic              overrun,
    output logic [MISS_W-1:0] miss_count,
    output logic [15:0]       frame_count,
    output logic              wd_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ERASE  = 3'd1,
        S_WAIT_E = 3'd2,
        S_UPDATE = 3'd3,
        S_DRAW   = 3'd4,
        S_WAIT_D = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SUB_W-1:0]  r_sub;
    logic              r_slow;
    logic              r_overrun;
    logic [MISS_W-1:0] r_miss_count;
    logic [15:0]       r_frame_count;

    logic w_accept;
    logic w_miss;
    logic w_wd_expire;

    assign w_accept = (r_state == S_IDLE) && enable && tick_in;
    // Any tick outside IDLE is dropped, regardless of enable.
    assign w_miss   = (r_state != S_IDLE) && tick_in;

`ifdef FRAME_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wd_err;
    logic            w_in_wait;
    logic            w_wd_fire;

    assign w_in_wait   = (r_state == S_WAIT_E) || (r_state == S_WAIT_D);
    // Counter holds 0 on the first wait cycle, so expiry at WD_CYCLES-1 gives
    // exactly WD_CYCLES cycles in the wait state.
    assign w_wd_expire = w_in_wait && (r_wd_cnt == WD_W'(WD_CYCLES - 1));
    // Only a real timeout is an error; a done arriving on the last cycle is not.
    assign w_wd_fire   = w_wd_expire &&
                         (((r_state == S_WAIT_E) && !erase_done) ||
                          ((r_state == S_WAIT_D) && !draw_done));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wd_cnt <= '0;
            r_wd_err <= 1'b0;
        end else begin
            if (r_state != w_next) begin
                r_wd_cnt <= '0;
            end else if (w_in_wait) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_fire) begin
                r_wd_err <= 1'b1;
            end
        end
    end

    assign wd_err = r_wd_err;
`else
    logic w_unused_wd;

    assign w_unused_wd = (WD_CYCLES == 0);
    assign w_wd_expire = 1'b0;
    assign wd_err      = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and Moore-decoded outputs
    always_comb begin
        w_next    = r_state;
        erase_go  = 1'b0;
        update_go = 1'b0;
        draw_go   = 1'b0;
        slow_step = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_ERASE;
                end
            end
            S_ERASE: begin
                erase_go = 1'b1;
                w_next   = S_WAIT_E;
            end
            S_WAIT_E: begin
                if (erase_done || w_wd_expire) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                update_go = 1'b1;
                slow_step = r_slow;
                w_next    = S_DRAW;
            end
            S_DRAW: begin
                draw_go = 1'b1;
                w_next  = S_WAIT_D;
            end
            S_WAIT_D: begin
                if (draw_done || w_wd_expire) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Frame counter and slow-frame sub-divider, both advanced on accept.
    // The sub-divider starts at 0 so the first frame after reset is slow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_frame_count <= 16'd0;
            r_sub         <= '0;
            r_slow        <= 1'b0;
        end else if (w_accept) begin
            r_frame_count <= r_frame_count + 16'd1;
            if (r_sub == '0) begin
                r_sub  <= SUB_W'(FRAME_DIV - 1);
                r_slow <= 1'b1;
            end else begin
                r_sub  <= r_sub - 1'b1;
                r_slow <= 1'b0;
            end
        end
    end

    // Overrun tracking; a miss in the same cycle as a clear wins and leaves
    // a count of one.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overrun    <= 1'b0;
            r_miss_count <= '0;
        end else if (clear_overrun) begin
            r_overrun    <= w_miss;
            r_miss_count <= w_miss ? MISS_W'(1) : '0;
        end else if (w_miss) begin
            r_overrun <= 1'b1;
            if (r_miss_count != '1) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign overrun     = r_overrun;
    assign miss_count  = r_miss_count;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_frame_scheduler.sv
module tb_frame_scheduler;

    localparam int FDIV = 30;
    localparam int WD   = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        tick_in = 1'b0;
    logic        erase_done = 1'b0;
    logic        draw_done = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        erase_go, update_go, draw_go, slow_step, busy, overrun, wd_err;
    logic [7:0]  miss_count;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    // Reference model: frames accepted since reset, dropped ticks, sticky flag.
    int m_frames = 0;
    int m_miss = 0;
    bit m_ovr = 1'b0;
    int slow_seen = 0;

    frame_scheduler #(
        .FRAME_DIV(FDIV),
        .SUB_W(5),
        .MISS_W(8),
        .WD_CYCLES(WD)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .enable(enable),
        .tick_in(tick_in),
        .erase_done(erase_done),
        .draw_done(draw_done),
        .clear_overrun(clear_overrun),
        .erase_go(erase_go),
        .update_go(update_go),
        .draw_go(draw_go),
        .slow_step(slow_step),
        .busy(busy),
        .overrun(overrun),
        .miss_count(miss_count),
        .frame_count(frame_count),
        .wd_err(wd_err)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        tick_in       = 1'b0;
        erase_done    = 1'b0;
        draw_done     = 1'b0;
        clear_overrun = 1'b0;
        enable        = 1'b1;
    endtask

    task automatic note_miss();
        m_miss = (m_miss < 255) ? m_miss + 1 : 255;
        m_ovr  = 1'b1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive_idle();
        repeat (3) cyc();
        resetn    = 1'b1;
        m_frames  = 0;
        m_miss    = 0;
        m_ovr     = 1'b0;
        slow_seen = 0;
        cyc();
    endtask

    task automatic test_reset();
        logic [6:0] got;
        resetn = 1'b0;
        drive_idle();
        tick_in = 1'b1;
        cyc();
        cyc();
        got = {erase_go, update_go, draw_go, slow_step, busy, overrun, wd_err};
        checks++;
        if (got !== 7'b0 || miss_count !== 8'd0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got flags=%b miss=%0d frames=%0d expected all zero",
                     got, miss_count, frame_count);
        end
        tick_in = 1'b0;
        resetn  = 1'b1;
        m_frames = 0; m_miss = 0; m_ovr = 1'b0; slow_seen = 0;
        cyc();
        got = {erase_go, update_go, draw_go, slow_step, busy, overrun, wd_err};
        checks++;
        if (got !== 7'b0) begin
            errors++;
            $display("FAIL reset_release got flags=%b expected 0000000", got);
        end
    endtask

    // One complete frame, starting from an IDLE cycle. Phase offsets follow
    // from the frame rules: ERASE at 1, WAIT_E for ew+1 cycles, UPDATE, DRAW,
    // WAIT_D for dw+1 cycles, IDLE at 6+ew+dw.
    // dmode: 0 = done pulses, 1 = pulses plus ignored pulses in ERASE/DRAW,
    //        2 = done inputs tied high (ew = dw = 0).
    task automatic test_frame(input int ew, input int dw, input int dmode,
                              input bit rnd_miss, input bit rnd_en);
        logic [4:0] exp;
        logic [4:0] got;
        bit         slow_this;
        int         len;
        len = 5 + ew + dw;
        got = {erase_go, update_go, draw_go, slow_step, busy};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL frame_idle_pre got=%b expected=00000", got);
        end
        slow_this = (m_frames % FDIV) == 0;
        m_frames  = (m_frames + 1) % 65536;
        enable    = 1'b1;
        tick_in   = 1'b1;
        clear_overrun = 1'b0;
        erase_done = (dmode == 2);
        draw_done  = (dmode == 2);
        cyc();
        for (int o = 1; o <= len; o++) begin
            exp = {o == 1, o == 3 + ew, o == 4 + ew, (o == 3 + ew) && slow_this, 1'b1};
            got = {erase_go, update_go, draw_go, slow_step, busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL frame_outputs offset=%0d got=%b expected=%b", o, got, exp);
            end
            if (slow_step === 1'b1) slow_seen++;
            if (o == 1) begin
                checks++;
                if (frame_count !== 16'(m_frames)) begin
                    errors++;
                    $display("FAIL frame_count got=%0d expected=%0d", frame_count, m_frames);
                end
            end
            if (dmode != 2) begin
                erase_done = (o == 2 + ew) || (dmode == 1 && o == 1);
                draw_done  = (o == len) || (dmode == 1 && o == 4 + ew);
            end
            tick_in = rnd_miss && ($urandom_range(0, 3) == 0);
            if (tick_in) note_miss();
            enable = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
        end
        drive_idle();
        got = {erase_go, update_go, draw_go, slow_step, busy};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL frame_idle_post got=%b expected=00000", got);
        end
        checks++;
        if (miss_count !== 8'(m_miss) || overrun !== m_ovr) begin
            errors++;
            $display("FAIL frame_misses got miss=%0d ovr=%b expected miss=%0d ovr=%b",
                     miss_count, overrun, m_miss, m_ovr);
        end
    endtask

    task automatic test_first_frame();
        do_reset();
        repeat (8) cyc();
        test_frame(0, 0, 2, 1'b0, 1'b0);
        checks++;
        if (frame_count !== 16'd1 || slow_seen != 1) begin
            errors++;
            $display("FAIL first_frame got frames=%0d slow=%0d expected frames=1 slow=1",
                     frame_count, slow_seen);
        end
    endtask

    task automatic test_slow_div();
        do_reset();
        for (int f = 0; f < 31; f++) begin
            test_frame($urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, 1'b0);
        end
        checks++;
        if (slow_seen != 2 || frame_count !== 16'd31) begin
            errors++;
            $display("FAIL slow_div got slow=%0d frames=%0d expected slow=2 frames=31",
                     slow_seen, frame_count);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            tick_in = 1'b1;
            cyc();
        end
        tick_in = 1'b0;
        checks++;
        if (miss_count !== 8'd3 || overrun !== 1'b1 || busy !== 1'b1 || update_go !== 1'b0) begin
            errors++;
            $display("FAIL overrun_count got miss=%0d ovr=%b busy=%b upd=%b expected 3 1 1 0",
                     miss_count, overrun, busy, update_go);
        end
        tick_in = 1'b1;
        clear_overrun = 1'b1;
        cyc();
        tick_in = 1'b0;
        checks++;
        if (miss_count !== 8'd1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_miss got miss=%0d ovr=%b expected miss=1 ovr=1",
                     miss_count, overrun);
        end
        cyc();
        clear_overrun = 1'b0;
        checks++;
        if (miss_count !== 8'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL clear_only got miss=%0d ovr=%b expected miss=0 ovr=0",
                     miss_count, overrun);
        end
        erase_done = 1'b1;
        cyc();
        erase_done = 1'b0;
        checks++;
        if (update_go !== 1'b1 || slow_step !== 1'b1) begin
            errors++;
            $display("FAIL overrun_update got upd=%b slow=%b expected 1 1", update_go, slow_step);
        end
        cyc();
        cyc();
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_finish got busy=%b expected 0", busy);
        end
        m_frames = 1;
        m_miss   = 0;
        m_ovr    = 1'b0;
    endtask

    task automatic test_enable();
        int draws;
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick_in = (i % 4 == 0);
            checks++;
            if ({erase_go, update_go, draw_go, busy} !== 4'b0) begin
                errors++;
                $display("FAIL disabled_idle cycle=%0d got=%b expected=0000", i,
                         {erase_go, update_go, draw_go, busy});
            end
            cyc();
        end
        tick_in = 1'b0;
        checks++;
        if (miss_count !== 8'(m_miss) || frame_count !== 16'(m_frames)) begin
            errors++;
            $display("FAIL disabled_counts got miss=%0d frames=%0d expected miss=%0d frames=%0d",
                     miss_count, frame_count, m_miss, m_frames);
        end
        enable = 1'b1;
        tick_in = 1'b1;
        erase_done = 1'b1;
        draw_done = 1'b1;
        m_frames++;
        cyc();
        enable = 1'b0;
        draws = 0;
        for (int o = 1; o <= 8; o++) begin
            if (draw_go === 1'b1) draws++;
            tick_in = (o == 2);
            if (tick_in) note_miss();
            cyc();
        end
        drive_idle();
        checks++;
        if (draws != 1 || busy !== 1'b0 || miss_count !== 8'(m_miss) ||
            frame_count !== 16'(m_frames)) begin
            errors++;
            $display("FAIL enable_drop got draws=%0d busy=%b miss=%0d frames=%0d expected 1 0 %0d %0d",
                     draws, busy, miss_count, frame_count, m_miss, m_frames);
        end
    endtask

    task automatic test_reset_midframe();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
        erase_done = 1'b1;
        cyc();
        erase_done = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({erase_go, update_go, draw_go, busy} !== 4'b0001) begin
            errors++;
            $display("FAIL reach_wait_d got=%b expected=0001", {erase_go, update_go, draw_go, busy});
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({erase_go, update_go, draw_go, slow_step, busy, overrun, wd_err} !== 7'b0 ||
            miss_count !== 8'd0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got flags=%b miss=%0d frames=%0d expected all zero",
                     {erase_go, update_go, draw_go, slow_step, busy, overrun, wd_err},
                     miss_count, frame_count);
        end
        cyc();
        resetn = 1'b1;
        m_frames = 0; m_miss = 0; m_ovr = 1'b0; slow_seen = 0;
        erase_done = 1'b1;
        draw_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if ({erase_go, update_go, draw_go, busy} !== 4'b0) begin
                errors++;
                $display("FAIL post_reset_quiet cycle=%0d got=%b expected=0000", i,
                         {erase_go, update_go, draw_go, busy});
            end
        end
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 150; f++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                checks++;
                if ({erase_go, update_go, draw_go, busy} !== 4'b0) begin
                    errors++;
                    $display("FAIL random_idle frame=%0d got=%b expected=0000", f,
                             {erase_go, update_go, draw_go, busy});
                end
                enable  = 1'($urandom_range(0, 1));
                tick_in = !enable && ($urandom_range(0, 1) == 1);
                clear_overrun = (f >= 130) && ($urandom_range(0, 7) == 0);
                if (clear_overrun) begin
                    m_miss = 0;
                    m_ovr  = 1'b0;
                end
                cyc();
            end
            clear_overrun = 1'b0;
            test_frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                       1'b1, 1'b1);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
        erase_done = 1'b1;
        cyc();
        erase_done = 1'b0;
        cyc();
        cyc();
        for (int o = 5; o < 5 + WD; o++) begin
            checks++;
            if (busy !== 1'b1 || wd_err !== 1'b0) begin
                errors++;
                $display("FAIL wd_waiting offset=%0d got busy=%b wd=%b expected 1 0", o, busy, wd_err);
            end
            cyc();
        end
`ifdef FRAME_WATCHDOG_EN
        checks++;
        if (busy !== 1'b0 || wd_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_expire got busy=%b wd=%b expected 0 1", busy, wd_err);
        end
`else
        repeat (30) cyc();
        checks++;
        if (busy !== 1'b1 || wd_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_hold got busy=%b wd=%b expected 1 0", busy, wd_err);
        end
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || wd_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_release got busy=%b wd=%b expected 0 0", busy, wd_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_slow_div();
        test_overrun();
        test_enable();
        test_reset_midframe();
        test_random();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences one animation frame per base tick: erase, state update, redraw, in that order, using a go/done handshake with the draw datapath.
- Consumes the 1-cycle tick pulse from the rate divider.
- Embeds a reloading frame sub-divider that issues a slow game-logic step every FRAME_DIV frames.
- Detects ticks that arrive while a frame is still in progress (overruns) and counts them.

Parameters:
- FRAME_DIV, 30: frames per slow_step; legal range 1..2^SUB_W.
- SUB_W, 5: width of the sub-divider counter.
- MISS_W, 8: width of the missed-tick counter.
- WD_CYCLES, 1023: watchdog limit in cycles per wait state; used only with FRAME_WATCHDOG_EN.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = accept new frames.
- tick_in  in  1  1-cycle frame tick from the rate divider.
- erase_done  in  1  erase datapath finished; level or pulse.
- draw_done  in  1  draw datapath finished; level or pulse.
- clear_overrun  in  1  1-cycle pulse; clears overrun and miss_count.
- erase_go  out  1  1-cycle start pulse for erase.
- update_go  out  1  1-cycle pulse; object positions advance.
- draw_go  out  1  1-cycle start pulse for draw.
- slow_step  out  1  1-cycle pulse, coincident with update_go on every FRAME_DIV-th frame.
- busy  out  1  1 whenever state != IDLE.
- overrun  out  1  sticky overrun flag.
- miss_count  out  MISS_W  saturating count of dropped ticks.
- frame_count  out  16  accepted frames, wraps at 0xFFFF -> 0.
- wd_err  out  1  sticky watchdog error; constant 0 without the macro.

Behaviour:
- Reset (resetn=0, asynchronous, any state): state=IDLE; all pulse outputs 0; busy=0; overrun=0; miss_count=0; frame_count=0; sub counter=0; wd_err=0.
- Outputs are Moore-decoded from registered state: erase_go=(state==ERASE), update_go=(state==UPDATE), draw_go=(state==DRAW), busy=(state!=IDLE).
- States and transitions:
  - IDLE -> ERASE when enable=1 and tick_in=1 (accepted frame); otherwise stay.
  - ERASE -> WAIT_E unconditionally (1 cycle).
  - WAIT_E -> UPDATE when erase_done=1 is sampled; otherwise stay.
  - UPDATE -> DRAW unconditionally (1 cycle).
  - DRAW -> WAIT_D unconditionally (1 cycle).
  - WAIT_D -> IDLE when draw_done=1 is sampled.
- done inputs are sampled only in WAIT_E/WAIT_D; a done asserted during the ERASE or DRAW cycle is ignored.
- Minimum frame: tick accepted at edge k; erase_go high in cycle k+1; earliest return to IDLE at edge k+5.
- Accepted frame, at the accept edge: frame_count+1.
- Sub-divider, at the accept edge:
  - if sub==0: reload FRAME_DIV-1 and mark the frame slow.
  - else: sub-1.
  - slow_step=1 during that frame's UPDATE cycle only.
  - The first frame after reset is slow. Frames 0, 30, 60 ... are slow with the default FRAME_DIV.
- FRAME_DIV=1: every frame is slow.
- Overrun: tick_in=1 while state!=IDLE sets overrun=1 and increments miss_count, saturating at all-ones. The dropped tick is not queued.
- A tick in the WAIT_D cycle that also samples draw_done is a miss; the state is still not IDLE that cycle.
- enable=0:
  - ticks in IDLE are ignored; not misses, no count change.
  - a frame already in progress runs to completion.
  - ticks during that frame still count as misses.
- clear_overrun=1 zeroes overrun and miss_count. If a miss occurs in the same cycle, the result is overrun=1, miss_count=1.
- Reset mid-frame abandons the frame immediately; no go pulse is issued after reset deasserts until a new tick is accepted.

Optional Feature:
- Macro: FRAME_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in WAIT_E and WAIT_D and clears on state entry.
  - If done has not arrived when the counter reaches WD_CYCLES, the FSM advances as if done were sampled (WAIT_E -> UPDATE, WAIT_D -> IDLE) and sets wd_err=1, sticky.
  - wd_err is cleared only by reset.
- Undefined: no counter; the wait states hold indefinitely; wd_err is tied to 0.

Test Plan:
- Reset, then tick at cycle 10 with erase_done and draw_done tied 1 -> erase_go @11, update_go+slow_step @13, draw_go @14, busy low from 16, frame_count=1.
- 31 frames with FRAME_DIV=30 -> slow_step on frames 1 and 31 only; frame_count=31.
- Hold erase_done=0 and pulse tick 3 times during WAIT_E -> overrun=1, miss_count=3. Then clear_overrun coincident with a 4th tick -> miss_count=1, overrun=1.
- enable=0, 5 ticks in IDLE -> no go pulses, miss_count unchanged. enable drops mid-frame -> frame completes, draw_go seen once.
- Assert resetn=0 during WAIT_D -> outputs zero asynchronously (before next edge); after release, no draw_go until next tick.
- With FRAME_WATCHDOG_EN, WD_CYCLES=8, draw_done held 0 -> IDLE exactly 8 cycles after WAIT_D entry, wd_err=1. Without the macro -> remains in WAIT_D, wd_err=0.
